// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_arb_pkg
// Brief   : Shared constants and FSM state encoding for the divider arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package div_arb_pkg;

    localparam int c_default_width          = 8;
    localparam int c_default_num_req        = 2;
    localparam int c_default_timeout_cycles = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick; search starts at ptr and wraps.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = c_default_num_req,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any_req
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!any_req && req_valid[w_idx]) begin
                grant[w_idx] = 1'b1;
                any_req      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : div_arbiter
// Brief   : Round-robin arbiter sharing one divider among NUM_REQ requesters.
//           Optional WAIT watchdog enabled by macro DIV_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ        = c_default_num_req,
    parameter int WIDTH          = c_default_width,
    parameter int TIMEOUT_CYCLES = c_default_timeout_cycles
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_error,
    output logic                     rsp_timeout,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    input  logic                     div_done,
    input  logic                     div_error,
    output logic                     busy
);

    localparam int c_ptr_w = $clog2(NUM_REQ);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_ptr_w-1:0]   r_winner;
    logic [c_ptr_w-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0]   w_grant;
    logic [NUM_REQ-1:0]   w_winner_onehot;
    logic                 w_any_req;
    logic                 w_timeout_hit;
    logic [WIDTH-1:0]     w_sel_dividend;
    logic [WIDTH-1:0]     w_sel_divisor;
    logic [WIDTH-1:0]     r_dividend;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_error;
    logic                 r_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .any_req   (w_any_req)
    );

    always_comb begin
        w_grant_idx    = '0;
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx    = c_ptr_w'(i);
                w_sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                w_sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_winner;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;

    // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout_hit = (r_state == ST_WAIT) && !div_done &&
                           (r_wait_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        rsp_valid    = '0;
        div_start    = 1'b0;
        busy         = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                req_ready    = w_winner_onehot;
                div_start    = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done || w_timeout_hit) begin
                    w_next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rsp_valid    = w_winner_onehot;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_winner    <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_error     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_winner   <= w_grant_idx;
                r_ptr      <= (w_grant_idx == c_ptr_w'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
                r_dividend <= w_sel_dividend;
                r_divisor  <= w_sel_divisor;
            end
            // A real div_done wins over a watchdog expiry in the same cycle.
            if (r_state == ST_WAIT && div_done) begin
                r_quotient  <= div_quotient;
                r_remainder <= div_remainder;
                r_error     <= div_error;
                r_timeout   <= 1'b0;
            end else if (w_timeout_hit) begin
                r_quotient  <= '0;
                r_remainder <= '0;
                r_error     <= 1'b1;
                r_timeout   <= 1'b1;
            end
        end
    end

    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign rsp_quotient  = r_quotient;
    assign rsp_remainder = r_remainder;
    assign rsp_error     = r_error;
    assign rsp_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_arbiter
// Brief   : Directed scoreboard bench for div_arbiter with a behavioural divider.
// Revision: 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

    localparam int NUM_REQ        = 2;
    localparam int WIDTH          = 8;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct {
        int         id;
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
        logic       tmo;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_dividend;
    logic [NUM_REQ*WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_quotient;
    logic [WIDTH-1:0]         rsp_remainder;
    logic                     rsp_error;
    logic                     rsp_timeout;
    logic                     div_start;
    logic [WIDTH-1:0]         div_dividend;
    logic [WIDTH-1:0]         div_divisor;
    logic [WIDTH-1:0]         model_q;
    logic [WIDTH-1:0]         model_r;
    logic                     model_done;
    logic                     model_err;
    logic                     stray_done;
    logic                     stray_err;
    logic                     div_done;
    logic                     div_error;
    logic                     busy;
    logic                     pending;
    bit                       div_enable = 1'b1;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rsp   = 0;
    int   order[3] = '{0, 1, 0};

    assign div_done  = model_done | stray_done;
    assign div_error = model_err | stray_err;

    div_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_error     (rsp_error),
        .rsp_timeout   (rsp_timeout),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (model_q),
        .div_remainder (model_r),
        .div_done      (div_done),
        .div_error     (div_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Divider model: done one cycle after it sees the start pulse, unless stalled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= 1'b0;
            model_done <= 1'b0;
            model_err  <= 1'b0;
            model_q    <= '0;
            model_r    <= '0;
        end else begin
            model_done <= 1'b0;
            if (div_start) begin
                pending <= 1'b1;
            end else if (pending && div_enable) begin
                pending    <= 1'b0;
                model_done <= 1'b1;
                if (div_divisor == 0) begin
                    model_q   <= 8'hFF;
                    model_r   <= div_dividend;
                    model_err <= 1'b1;
                end else begin
                    model_q   <= div_dividend / div_divisor;
                    model_r   <= div_dividend % div_divisor;
                    model_err <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != 0) check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            if (rsp_valid != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(1 << mon_e.id));
                    check("rsp_quotient", 32'(rsp_quotient), 32'(mon_e.q));
                    check("rsp_remainder", 32'(rsp_remainder), 32'(mon_e.r));
                    check("rsp_error", 32'(rsp_error), 32'(mon_e.err));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.tmo));
                end
                n_rsp++;
            end
        end
    end

    task automatic drive_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]             = 1'b1;
        req_dividend[i*WIDTH +: WIDTH] = a;
        req_divisor[i*WIDTH +: WIDTH]  = b;
    endtask

    task automatic wait_ready(input int limit, output int n, output int idx);
        n   = 0;
        idx = -1;
        while (n < limit && idx < 0) begin
            @(posedge clk); #1;
            n++;
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
        end
        if (idx < 0) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int limit, output int n);
        bit seen = 1'b0;
        n = 0;
        while (n < limit && !seen) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid != 0) seen = 1'b1;
        end
        if (!seen) check("rsp_timeout_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (n < limit && (sb.size() != 0 || busy)) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n, idx, snap;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        stray_done   = 1'b0;
        stray_err    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_outputs", 32'({req_ready, rsp_valid, div_start, rsp_error, rsp_timeout}), 32'd0);
        check("reset_data", {rsp_quotient, rsp_remainder, div_dividend, div_divisor}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single request 200/7
        sb.push_back('{id: 0, q: 8'd28, r: 8'd4, err: 1'b0, tmo: 1'b0});
        drive_req(0, 8'd200, 8'd7);
        wait_ready(20, n, idx);
        check("t1_ready_lat", n, 32'd1);
        check("t1_ready_idx", idx, 32'd0);
        check("t1_div_start", 32'(div_start), 32'd1);
        check("t1_div_operands", 32'({div_dividend, div_divisor}), {16'd0, 8'd200, 8'd7});
        check("t1_busy", 32'(busy), 32'd1);
        req_valid[0] = 1'b0;
        wait_rsp(20, n);
        check("t1_rsp_lat", n, 32'd3);
        wait_drain(20);

        // Both held: grants 0,1,0 from a freshly reset pointer
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back('{id: 0, q: 8'd10, r: 8'd0, err: 1'b0, tmo: 1'b0});
        sb.push_back('{id: 1, q: 8'd10, r: 8'd0, err: 1'b0, tmo: 1'b0});
        sb.push_back('{id: 0, q: 8'd10, r: 8'd0, err: 1'b0, tmo: 1'b0});
        drive_req(0, 8'd100, 8'd10);
        drive_req(1, 8'd50, 8'd5);
        for (int g = 0; g < 3; g++) begin
            wait_ready(40, n, idx);
            check("t2_grant_order", idx, order[g]);
            if (g == 2) begin
                req_valid = '0;
                req_dividend[7:0] = 8'd0;
                req_divisor[7:0]  = 8'd0;
            end
        end
        wait_drain(40);

        // Divide by zero from requester 1
        sb.push_back('{id: 1, q: 8'hFF, r: 8'd9, err: 1'b1, tmo: 1'b0});
        drive_req(1, 8'd9, 8'd0);
        wait_ready(20, n, idx);
        check("t3_ready_idx", idx, 32'd1);
        req_valid[1] = 1'b0;
        wait_drain(20);

        // Reset while waiting on a stalled divider
        div_enable = 1'b0;
        drive_req(0, 8'd20, 8'd3);
        wait_ready(20, n, idx);
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t4_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t4_busy_reset", 32'(busy), 32'd0);
        check("t4_outputs_reset", 32'({req_ready, rsp_valid, div_start, rsp_error, rsp_timeout}), 32'd0);
        check("t4_data_reset", {rsp_quotient, rsp_remainder, div_dividend, div_divisor}, 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        div_enable = 1'b1;
        snap       = n_rsp;
        @(posedge clk); #1;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t4_no_rsp", n_rsp, snap);
        check("t4_idle", 32'(busy), 32'd0);

        // Stray done/error while idle
        snap = n_rsp;
        stray_done = 1'b1;
        stray_err  = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        stray_err  = 1'b0;
        check("t5_stray_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_stray_no_rsp", n_rsp, snap);

        // Pointer must be back at 0 after the mid-operation reset
        sb.push_back('{id: 0, q: 8'd4, r: 8'd0, err: 1'b0, tmo: 1'b0});
        sb.push_back('{id: 1, q: 8'd3, r: 8'd1, err: 1'b0, tmo: 1'b0});
        drive_req(0, 8'd8, 8'd2);
        drive_req(1, 8'd10, 8'd3);
        wait_ready(20, n, idx);
        check("t6_ptr_reset", idx, 32'd0);
        req_valid[0] = 1'b0;
        wait_ready(20, n, idx);
        check("t6_second", idx, 32'd1);
        req_valid[1] = 1'b0;
        wait_drain(40);

`ifdef DIV_ARB_TIMEOUT_EN
        div_enable = 1'b0;
        sb.push_back('{id: 0, q: 8'd0, r: 8'd0, err: 1'b1, tmo: 1'b1});
        drive_req(0, 8'd5, 8'd1);
        wait_ready(20, n, idx);
        req_valid[0] = 1'b0;
        wait_rsp(60, n);
        check("t7_timeout_lat", n, 32'd17);
        wait_drain(20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one divider (2..4).
REQ-002 Parameter WIDTH, default 8, operand and result width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, watchdog limit in clk cycles (used only under DIV_ARB_TIMEOUT_EN).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  per-requester request; held high with operands stable until its req_ready pulse.
REQ-007 req_dividend  in  NUM_REQ*WIDTH  packed dividends; requester i occupies slice [i*WIDTH +: WIDTH].
REQ-008 req_divisor  in  NUM_REQ*WIDTH  packed divisors, same packing.
REQ-009 req_ready  out  NUM_REQ  one-cycle grant/accept pulse, at most one bit set.
REQ-010 rsp_valid  out  NUM_REQ  one-cycle result pulse to the granted requester, at most one bit set.
REQ-011 rsp_quotient, rsp_remainder  out  WIDTH each  result, valid while any rsp_valid bit is high.
REQ-012 rsp_error  out  1  divide-by-zero or timeout, valid with rsp_valid.
REQ-013 rsp_timeout  out  1  result produced by the watchdog, valid with rsp_valid.
REQ-014 div_start  out  1  one-cycle start pulse to the divider.
REQ-015 div_dividend, div_divisor  out  WIDTH each  latched operands, stable from the div_start cycle to the response.
REQ-016 div_quotient, div_remainder, div_done, div_error  in  WIDTH, WIDTH, 1, 1  divider results; done is a pulse.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESPOND.
REQ-019 IDLE: if any req_valid is high, SHALL pick winner w by round-robin, latch its operands, and go to ISSUE at the next edge.
REQ-020 ISSUE (one cycle): req_ready[w]=1, div_start=1, then WAIT.
REQ-021 WAIT: on the cycle div_done=1, SHALL latch quotient, remainder and error, then go to RESPOND.
REQ-022 RESPOND (one cycle): rsp_valid[w]=1 with the latched results, then IDLE.
REQ-023 Minimum latency from req_valid to rsp_valid SHALL be 3 + divider cycles; at most one operation SHALL be in flight.
REQ-024 Round-robin: the priority pointer resets to 0; after granting w it SHALL become (w+1) mod NUM_REQ; the search starts at the pointer.
REQ-025 req_valid SHALL be sampled only in IDLE; a request dropped before its grant is never served.
REQ-026 div_done or div_error outside WAIT SHALL be ignored.
REQ-027 Latched results SHALL hold until the next latch; with rsp_valid low their value is don't-care.
REQ-028 Operand change by a requester after its req_ready SHALL NOT affect the operation in flight.

Reset
REQ-029 rst SHALL immediately force IDLE, pointer 0, and all outputs and latched data to 0, including mid-operation; the aborted requester SHALL receive no rsp_valid.

Configuration
REQ-030 With macro DIV_ARB_TIMEOUT_EN defined, a WAIT-cycle counter SHALL, after TIMEOUT_CYCLES cycles without div_done, enter RESPOND with rsp_error=1, rsp_timeout=1 and quotient and remainder 0.
REQ-031 Without DIV_ARB_TIMEOUT_EN, WAIT SHALL last indefinitely and rsp_timeout SHALL be tied to 0; ports are identical in both builds.

Structure
REQ-032 Package div_arb_pkg SHALL hold the state enum, the default WIDTH, NUM_REQ and TIMEOUT_CYCLES constants.
REQ-033 Sub-module rr_arbiter SHALL take req_valid and the pointer and return a one-hot grant plus an any_req flag.

Verification
REQ-034 Requester 0 requests 200/7 -> req_ready[0] 1 cycle later, div_start same cycle, rsp_valid[0] with quotient 28, remainder 4, error 0.
REQ-035 Both requesters held high (0: 100/10, 1: 50/5) -> grant order 0 then 1 then 0; rsp quotients 10 then 10; never two ready bits at once.
REQ-036 Requester 1 requests 9/0, divider returns error -> rsp_valid[1] with rsp_error=1 and rsp_timeout=0.
REQ-037 rst pulsed in WAIT -> busy=0 and all outputs 0 immediately; a later div_done pulse produces no rsp_valid.
REQ-038 DIV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, div_done never asserted -> rsp_valid after 16 WAIT cycles with rsp_error=1, rsp_timeout=1.
REQ-039 Stray div_done in IDLE with no request pending -> no state change and no rsp_valid.
